// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package mips_fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry shift FIFO; the head register feeds decode directly and reads 0 when empty.
module fetch_queue
    import mips_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         pop_ok_c;
    logic         push_ok_c;

    // tail is kept zero whenever count < 2 so a pop can always shift it into head
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        pop_ok_c  = pop && (count_q != 2'd0);
        push_ok_c = push && ((count_q != 2'd2) || pop_ok_c);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = 2'd0;
        end else begin
            case ({push_ok_c, pop_ok_c})
                2'b10: begin
                    if (count_q == 2'd0) head_d = push_data;
                    else                 tail_d = push_data;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    tail_d  = '0;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = push_data;
                    end else begin
                        head_d = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC sequencer: drives the ROM address, checks the fetch window and feeds decode through a 2-entry queue.
module instruction_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           MEMORY_DEPTH = 2048,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0] imem_instruction,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [DATA_WIDTH-1:0] inst_pc,
    output logic                  fault
);

    localparam logic [DATA_WIDTH-1:0] WINDOW_BYTES = DATA_WIDTH'(WORD_BYTES * MEMORY_DEPTH);
    localparam logic [DATA_WIDTH-1:0] PC_STEP      = DATA_WIDTH'(WORD_BYTES);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] pc_offset_c;
    logic                  pc_bad_c;
    logic                  pop_c;
    logic                  push_c;
    logic                  push_allowed_c;
    logic [1:0]            q_count;
    fetch_entry_t          q_head;
    fetch_entry_t          q_push_data;

    // unsigned wrap makes PCs below the base land far outside the window
    assign pc_offset_c = fetch_pc_q - RESET_PC;
    assign pc_bad_c    = (fetch_pc_q[1:0] != 2'b00) || (pc_offset_c >= WINDOW_BYTES);

    assign pop_c          = inst_valid && inst_ready && !redirect_valid;
    assign push_allowed_c = (q_count != 2'd2) || pop_c;
    assign q_push_data    = '{instr: XLEN'(imem_instruction), pc: XLEN'(fetch_pc_q)};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push_c     = 1'b0;
        if (redirect_valid) begin
            state_d    = FETCH;
            fetch_pc_d = redirect_pc;
        end else if (state_q == FETCH) begin
            if (pc_bad_c) begin
                state_d = FAULT;
            end else if (push_allowed_c) begin
                push_c     = 1'b1;
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_queue u_fetch_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .pop       (pop_c),
        .flush     (redirect_valid),
        .push_data (q_push_data),
        .count     (q_count),
        .head      (q_head)
    );

    assign imem_address = fetch_pc_q;
    assign inst_valid   = (q_count != 2'd0);
    assign inst         = DATA_WIDTH'(q_head.instr);
    assign inst_pc      = DATA_WIDTH'(q_head.pc);
    assign fault        = (state_q == FAULT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed stimulus, decoupled pop monitor.
module tb_instruction_fetch_unit;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk            = 1'b0;
    logic        reset          = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        inst_ready     = 1'b0;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        logic [31:0] idx;
        idx = (addr - BASE) >> 2;
        if (idx >= 32'd2048) return 32'hDEAD_BEEF;
        if (idx == 32'd0)    return 32'h2008_0005;
        if (idx == 32'd1)    return 32'h2009_0003;
        return 32'h8C00_0000 | idx;
    endfunction

    assign imem_instruction = rom_word(imem_address);

    instruction_fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .fault            (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = rom_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        step(1);
        redirect_valid = 1'b0;
    endtask

    // Monitor: every accepted head must match the next expected entry
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && !redirect_valid && inst_valid === 1'b1 && inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got pc 0x%08h expected no entry", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", inst_pc, e.pc);
                    check("pop_inst", inst, e.instr);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // reset values
        step(2);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_pc", inst_pc, 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_addr", imem_address, BASE);

        // backpressure from reset release: queue fills in two cycles, fetch holds
        reset = 1'b0;
        step(1);
        check("first_valid", 32'(inst_valid), 32'd1);
        check("first_pc", inst_pc, BASE);
        check("first_addr", imem_address, BASE + 32'h4);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("bp_addr", imem_address, BASE + 32'h8);
            check("bp_head_pc", inst_pc, BASE);
            check("bp_head_inst", inst, 32'h2008_0005);
            check("bp_valid", 32'(inst_valid), 32'd1);
        end

        // release: in-order delivery, one per cycle
        expect_seq(BASE, 6);
        inst_ready = 1'b1;
        step(6);
        inst_ready = 1'b0;
        step(2);
        check("drain_a", 32'(exp_q.size()), 32'd0);

        // redirect while full; stale entries must never appear
        inst_ready = 1'b1;
        redirect_to(BASE + 32'h100);
        check("redir_flush_valid", 32'(inst_valid), 32'd0);
        expect_seq(BASE + 32'h100, 2);
        step(1);
        check("redir_valid", 32'(inst_valid), 32'd1);
        check("redir_pc", inst_pc, BASE + 32'h100);
        step(2);
        inst_ready = 1'b0;
        step(1);
        check("drain_b", 32'(exp_q.size()), 32'd0);

        // misaligned redirect faults one cycle later
        redirect_to(BASE + 32'h102);
        check("mis_fault_early", 32'(fault), 32'd0);
        step(1);
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_valid", 32'(inst_valid), 32'd0);
        check("mis_addr", imem_address, BASE + 32'h102);
        step(2);
        check("mis_fault_hold", 32'(fault), 32'd1);
        check("mis_addr_hold", imem_address, BASE + 32'h102);
        redirect_to(BASE);
        check("mis_clear", 32'(fault), 32'd0);

        // walk off the end of the window
        redirect_to(BASE + 32'h1FE0);
        expect_seq(BASE + 32'h1FE0, 8);
        inst_ready = 1'b1;
        step(8);
        check("end_addr", imem_address, BASE + 32'h2000);
        check("end_fault_early", 32'(fault), 32'd0);
        step(1);
        check("end_fault", 32'(fault), 32'd1);
        check("end_valid", 32'(inst_valid), 32'd0);
        step(3);
        check("end_addr_hold", imem_address, BASE + 32'h2000);
        check("drain_c", 32'(exp_q.size()), 32'd0);
        inst_ready = 1'b0;

        // below-base redirect wraps and fails the window check
        redirect_to(32'h003F_FFFC);
        check("wrap_fault_early", 32'(fault), 32'd0);
        step(1);
        check("wrap_fault", 32'(fault), 32'd1);
        check("wrap_valid", 32'(inst_valid), 32'd0);

        // reset mid-stream with two entries queued
        redirect_to(BASE + 32'h40);
        step(2);
        check("pre_rst_valid", 32'(inst_valid), 32'd1);
        check("pre_rst_pc", inst_pc, BASE + 32'h40);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("mid_rst_valid", 32'(inst_valid), 32'd0);
        check("mid_rst_addr", imem_address, BASE);
        check("mid_rst_fault", 32'(fault), 32'd0);
        check("mid_rst_inst", inst, 32'd0);
        expect_seq(BASE, 3);
        inst_ready = 1'b1;
        step(4);
        inst_ready = 1'b0;
        step(1);
        check("drain_d", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequences the combinational program memory ROM. Owns the fetch program counter, drives the ROM byte address every cycle, and captures each returned instruction with its PC into a 2-entry fetch queue. The queue feeds the decode stage over a valid/ready handshake. Sits between the program memory and the decode stage; branch/jump redirects from the execute stage flush the queue and restart fetch.

## Interface
- DATA_WIDTH, 32, instruction and address width
- MEMORY_DEPTH, 2048, ROM depth in words; sets the valid fetch window
- RESET_PC, 32'h0040_0000, text-segment base; PC after reset

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- imem_address  output  DATA_WIDTH  byte address to the program memory; equals fetch_pc
- imem_instruction  input  DATA_WIDTH  combinational ROM data for imem_address, same cycle
- redirect_valid  input  1  load redirect_pc into fetch_pc and flush the queue
- redirect_pc  input  DATA_WIDTH  redirect target byte address
- inst_valid  output  1  queue head is valid
- inst_ready  input  1  decode accepts head this cycle
- inst  output  DATA_WIDTH  queue head instruction; 0 (NOP) when empty
- inst_pc  output  DATA_WIDTH  PC of head; 0 when empty
- fault  output  1  fetch stopped on a misaligned or out-of-window PC

## Operation
- States: FETCH, FAULT. Reset enters FETCH with fetch_pc=RESET_PC and the queue empty.
- Reset output values: imem_address=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fault=0.
- Window check is combinational on fetch_pc:
  - bad when fetch_pc[1:0]≠0, or
  - bad when (fetch_pc−RESET_PC) mod 2^32 ≥ 4·MEMORY_DEPTH.
  - The subtraction is 32-bit unsigned, so PCs below the base wrap high and fail.
- FETCH, PC good, push allowed: push {imem_instruction, fetch_pc}, then fetch_pc += 4 (mod 2^32).
- FETCH, PC bad: no push, go to FAULT, fetch_pc holds.
- FAULT: fault=1, no pushes. Queued entries still drain normally.
- Push allowed when count<2, or when count==2 and a pop happens in the same cycle.
- Pop: inst_valid && inst_ready. Handshake rules:
  - inst, inst_pc and inst_valid stay stable until popped or flushed.
  - inst_ready may toggle freely.
- Redirect (either state): queue count→0, fetch_pc←redirect_pc, state→FETCH, fault→0.
  - Redirect overrides any push or pop in that cycle. No pop is recorded.
  - A bad redirect_pc faults on the following cycle.
- Priority: reset > redirect > push/pop.

## Timing
- Single clock domain. All state updates on the rising clk edge.
- imem_address is registered (fetch_pc). The ROM read is same-cycle combinational.
- Reset release or redirect to first inst_valid: 1 cycle.
- Steady state with inst_ready held high: one instruction per cycle; the queue holds at 1 entry.
- Backpressure: with inst_ready low, the queue fills in 2 cycles, then fetch_pc holds.
- Fault: fault rises 1 cycle after the bad PC is presented.
- Reset asserted mid-stream: next edge discards queue contents and returns to the reset values above.

## Structure
- Shared package mips_fetch_pkg:
  - fetch state enum {FETCH, FAULT}
  - RESET_PC default, WORD_BYTES=4
  - queue entry struct {instr, pc}
- Sub-module fetch_queue:
  - 2-entry FIFO with push, pop, flush, count, head outputs
  - Simultaneous push and pop allowed when full
  - Flush has priority over push and pop
- Top level holds fetch_pc, the state register and the window check.

## Test plan
- Reset, ROM[0]=0x2008_0005, ROM[1]=0x2009_0003, inst_ready=1:
  - cycle 1: inst_valid=1, inst=0x2008_0005, inst_pc=0x0040_0000
  - cycle 2: inst=0x2009_0003, inst_pc=0x0040_0004
- inst_ready=0 for 4 cycles:
  - queue holds 2 entries; imem_address stops at 0x0040_0008; head stable
  - release: entries arrive in order with no loss or duplication
- redirect_pc=0x0040_0100 while queue is full and inst_ready=1:
  - next cycle: inst_pc=0x0040_0100
  - pre-redirect entries never appear
- redirect_pc=0x0040_0102:
  - fault=1 one cycle later; inst_valid=0; imem_address holds 0x0040_0102
  - redirect to 0x0040_0000 clears fault
- Sequential fetch reaches 0x0040_2000 (MEMORY_DEPTH=2048):
  - fault asserts
  - last instruction delivered has inst_pc=0x0040_1FFC
- redirect_pc=0x003F_FFFC: fault asserts (wrapped offset fails the window check).
- reset pulsed mid-stream with 2 entries queued: next cycle inst_valid=0, imem_address=0x0040_0000, fault=0.
